// File: rtl/vram_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : vram_fetch_responder
// Function : Round-robin responder that serves three renderer fetch initiators
//            from one shared synchronous VRAM read port.
// Revision : 1.0  initial release
// ============================================================================
module vram_fetch_responder #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] l0_addr,
    input  logic [15:0] l1_addr,
    input  logic [15:0] spr_addr,
    input  logic        l0_strobe,
    input  logic        l1_strobe,
    input  logic        spr_strobe,
    output logic        l0_ack,
    output logic        l1_ack,
    output logic        spr_ack,
    output logic [31:0] l0_rddata,
    output logic [31:0] l1_rddata,
    output logic [31:0] spr_rddata,
    output logic [14:0] vram_addr,
    output logic        vram_rden,
    input  logic [31:0] vram_rddata
);

    // Stage 0 of the tag pipe is aligned with vram_rden; the last stage is
    // aligned with valid vram_rddata.
    localparam int c_DEPTH = RD_LATENCY + 1;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [2:0]  w_strobe;
    logic [3:0]  w_eligible;
    logic [1:0]  w_scan;
    logic        w_grant_vld;
    logic [1:0]  w_grant_port;
    logic [2:0]  w_grant_oh;
    logic [14:0] w_grant_addr;
    logic        w_ret_vld;
    logic [1:0]  w_ret_port;
    logic [2:0]  w_ret_oh;
    logic [2:0]  w_ack_next;
    logic        w_unused_bit15;

    logic [2:0]         r_inflight;
    logic [2:0]         r_cancel;
    logic [2:0]         r_ack;
    logic [1:0]         r_last;
    logic               r_vram_rden;
    logic [14:0]        r_vram_addr;
    logic [c_DEPTH-1:0] r_tag_vld;
    logic [1:0]         r_tag_port [c_DEPTH];
    logic [31:0]        r_rddata   [3];

    assign w_strobe       = {spr_strobe, l1_strobe, l0_strobe};
    assign w_eligible     = {1'b0, w_strobe & ~r_inflight};
    assign w_unused_bit15 = l0_addr[15] ^ l1_addr[15] ^ spr_addr[15];

    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_port = r_last;
        w_scan       = r_last;
        for (int k = 0; k < 3; k++) begin
            w_scan = f_next(w_scan);
            if (!w_grant_vld && w_eligible[w_scan]) begin
                w_grant_vld  = 1'b1;
                w_grant_port = w_scan;
            end
        end
    end

    always_comb begin
        w_grant_addr = spr_addr[14:0];
        case (w_grant_port)
            2'd0:    w_grant_addr = l0_addr[14:0];
            2'd1:    w_grant_addr = l1_addr[14:0];
            default: w_grant_addr = spr_addr[14:0];
        endcase
    end

    assign w_grant_oh = w_grant_vld ? (3'b001 << w_grant_port) : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int k = 0; k < c_DEPTH; k++) begin
                r_tag_port[k] <= 2'd0;
            end
        end else begin
            r_tag_vld[0]  <= w_grant_vld;
            r_tag_port[0] <= w_grant_port;
            for (int k = 1; k < c_DEPTH; k++) begin
                r_tag_vld[k]  <= r_tag_vld[k-1];
                r_tag_port[k] <= r_tag_port[k-1];
            end
        end
    end

    assign w_ret_vld  = r_tag_vld[c_DEPTH-1];
    assign w_ret_port = r_tag_port[c_DEPTH-1];
    assign w_ret_oh   = w_ret_vld ? (3'b001 << w_ret_port) : 3'b000;

    // Strobe is judged at retire so the ack itself never depends on strobe.
    assign w_ack_next = w_ret_oh & ~r_cancel & w_strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight  <= 3'b000;
            r_cancel    <= 3'b000;
            r_ack       <= 3'b000;
            r_last      <= 2'd2;
            r_vram_rden <= 1'b0;
            r_vram_addr <= '0;
        end else begin
            r_inflight  <= (r_inflight | w_grant_oh) & ~w_ret_oh;
            r_cancel    <= (r_cancel | (r_inflight & ~w_strobe)) & ~w_ret_oh;
            r_ack       <= w_ack_next;
            r_vram_rden <= w_grant_vld;
            if (w_grant_vld) begin
                r_last      <= w_grant_port;
                r_vram_addr <= w_grant_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 3; p++) begin
                r_rddata[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (w_ack_next[p]) begin
                    r_rddata[p] <= vram_rddata;
                end
            end
        end
    end

    assign l0_ack     = r_ack[0];
    assign l1_ack     = r_ack[1];
    assign spr_ack    = r_ack[2];
    assign l0_rddata  = r_rddata[0];
    assign l1_rddata  = r_rddata[1];
    assign spr_rddata = r_rddata[2];
    assign vram_addr  = r_vram_addr;
    assign vram_rden  = r_vram_rden;

endmodule
`default_nettype wire

// File: tb/tb_vram_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_fetch_responder
// Function : Directed bench for vram_fetch_responder at RD_LATENCY 1 and 2.
// Revision : 1.0  initial release
// ============================================================================
module tb_vram_fetch_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: RD_LATENCY=1, instance B: RD_LATENCY=2
    logic [2:0]  a_req = 3'b000, b_req = 3'b000;
    logic [15:0] a_addr [3];
    logic [15:0] b_addr [3];
    logic [2:0]  a_ack, b_ack;
    logic [2:0]  a_strobe, b_strobe;
    logic [31:0] a_rd [3];
    logic [31:0] b_rd [3];
    logic [14:0] a_vaddr, b_vaddr;
    logic        a_rden, b_rden;
    logic [31:0] a_vdata, b_vd1, b_vdata;

    // Initiators mask their strobe with ack.
    assign a_strobe = a_req & ~a_ack;
    assign b_strobe = b_req & ~b_ack;

    function automatic logic [31:0] vram_word(input logic [14:0] a);
        if (a == 15'h1234) return 32'hDEADBEEF;
        return {8'hC3, 1'b0, a, ~a[7:0]};
    endfunction

    always @(posedge clk) begin
        a_vdata <= a_rden ? vram_word(a_vaddr) : 32'hBAD0BAD0;
        b_vd1   <= b_rden ? vram_word(b_vaddr) : 32'hBAD0BAD0;
        b_vdata <= b_vd1;
    end

    vram_fetch_responder #(.RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .l0_addr(a_addr[0]), .l1_addr(a_addr[1]), .spr_addr(a_addr[2]),
        .l0_strobe(a_strobe[0]), .l1_strobe(a_strobe[1]), .spr_strobe(a_strobe[2]),
        .l0_ack(a_ack[0]), .l1_ack(a_ack[1]), .spr_ack(a_ack[2]),
        .l0_rddata(a_rd[0]), .l1_rddata(a_rd[1]), .spr_rddata(a_rd[2]),
        .vram_addr(a_vaddr), .vram_rden(a_rden), .vram_rddata(a_vdata)
    );

    vram_fetch_responder #(.RD_LATENCY(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .l0_addr(b_addr[0]), .l1_addr(b_addr[1]), .spr_addr(b_addr[2]),
        .l0_strobe(b_strobe[0]), .l1_strobe(b_strobe[1]), .spr_strobe(b_strobe[2]),
        .l0_ack(b_ack[0]), .l1_ack(b_ack[1]), .spr_ack(b_ack[2]),
        .l0_rddata(b_rd[0]), .l1_rddata(b_rd[1]), .spr_rddata(b_rd[2]),
        .vram_addr(b_vaddr), .vram_rden(b_rden), .vram_rddata(b_vdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        a_req = 3'b000;
        b_req = 3'b000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if ({a_ack, b_ack, a_rden, b_rden} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000000", {a_ack, b_ack, a_rden, b_rden});
        end
        total++;
        if ({a_vaddr, b_vaddr} !== 30'h0) begin
            bad++;
            $display("FAIL reset_vaddr: got %h/%h want 0000/0000", a_vaddr, b_vaddr);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (a_rd[i] !== 32'h0 || b_rd[i] !== 32'h0) begin
                bad++;
                $display("FAIL reset_rddata port%0d: got %h/%h want 0", i, a_rd[i], b_rd[i]);
            end
        end
    endtask

    task automatic test_single;
        do_reset();
        a_addr[2] = 16'h1234;
        a_req[2]  = 1'b1;
        tick();
        total++;
        if (a_rden !== 1'b1 || a_vaddr !== 15'h1234) begin
            bad++;
            $display("FAIL single_issue: got rden=%b addr=%h want 1/1234", a_rden, a_vaddr);
        end
        tick();
        total++;
        if (a_ack !== 3'b000) begin
            bad++;
            $display("FAIL single_early_ack: got %b want 000", a_ack);
        end
        tick();
        total++;
        if (a_ack !== 3'b100 || a_rd[2] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_ack: got ack=%b data=%h want 100/deadbeef", a_ack, a_rd[2]);
        end
        a_req[2] = 1'b0;
        tick();
        total++;
        if (a_ack !== 3'b000 || a_rden !== 1'b0 || a_rd[2] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_after: got ack=%b rden=%b data=%h want 000/0/deadbeef",
                     a_ack, a_rden, a_rd[2]);
        end
    endtask

    task automatic test_bit15;
        a_addr[0] = 16'h8010;
        a_req[0]  = 1'b1;
        tick();
        total++;
        if (a_rden !== 1'b1 || a_vaddr !== 15'h0010) begin
            bad++;
            $display("FAIL bit15_addr: got rden=%b addr=%h want 1/0010", a_rden, a_vaddr);
        end
        tick();
        tick();
        total++;
        if (a_ack !== 3'b001 || a_rd[0] !== vram_word(15'h0010)) begin
            bad++;
            $display("FAIL bit15_ack: got ack=%b data=%h want 001/%h", a_ack, a_rd[0],
                     vram_word(15'h0010));
        end
        a_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        logic [14:0] exp_addr [3];
        exp_addr = '{15'h0001, 15'h0002, 15'h0003};
        do_reset();
        a_addr[0] = 16'h0001;
        a_addr[1] = 16'h0002;
        a_addr[2] = 16'h0003;
        a_req     = 3'b111;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c < 3) begin
                total++;
                if (a_rden !== 1'b1 || a_vaddr !== exp_addr[c]) begin
                    bad++;
                    $display("FAIL contend_issue%0d: got rden=%b addr=%h want 1/%h",
                             c, a_rden, a_vaddr, exp_addr[c]);
                end
            end
            if (c >= 2) begin
                total++;
                if (a_ack !== (3'b001 << (c - 2)) || a_rd[c-2] !== vram_word(exp_addr[c-2])) begin
                    bad++;
                    $display("FAIL contend_ack%0d: got ack=%b data=%h want %b/%h", c - 2,
                             a_ack, a_rd[c-2], 3'b001 << (c - 2), vram_word(exp_addr[c-2]));
                end
                a_req[c-2] = 1'b0;
            end
        end
        tick();
        // second round: last grant was spr, so l1 is first, l0 skipped
        a_addr[1] = 16'h0011;
        a_addr[2] = 16'h0022;
        a_req     = 3'b110;
        tick();
        total++;
        if (a_rden !== 1'b1 || a_vaddr !== 15'h0011) begin
            bad++;
            $display("FAIL round2_first: got rden=%b addr=%h want 1/0011", a_rden, a_vaddr);
        end
        tick();
        total++;
        if (a_rden !== 1'b1 || a_vaddr !== 15'h0022) begin
            bad++;
            $display("FAIL round2_second: got rden=%b addr=%h want 1/0022", a_rden, a_vaddr);
        end
        tick();
        total++;
        if (a_ack !== 3'b010 || a_rd[1] !== vram_word(15'h0011)) begin
            bad++;
            $display("FAIL round2_ack_l1: got ack=%b data=%h want 010/%h", a_ack, a_rd[1],
                     vram_word(15'h0011));
        end
        a_req[1] = 1'b0;
        tick();
        total++;
        if (a_ack !== 3'b100 || a_rd[2] !== vram_word(15'h0022)) begin
            bad++;
            $display("FAIL round2_ack_spr: got ack=%b data=%h want 100/%h", a_ack, a_rd[2],
                     vram_word(15'h0022));
        end
        a_req[2] = 1'b0;
        tick();
    endtask

    task automatic test_abort;
        do_reset();
        a_addr[1] = 16'h0030;
        a_req[1]  = 1'b1;
        tick();
        total++;
        if (a_rden !== 1'b1 || a_vaddr !== 15'h0030) begin
            bad++;
            $display("FAIL abort_issue: got rden=%b addr=%h want 1/0030", a_rden, a_vaddr);
        end
        tick();
        a_req[1] = 1'b0;
        tick();
        a_addr[1] = 16'h0040;
        a_req[1]  = 1'b1;
        total++;
        if (a_ack !== 3'b000) begin
            bad++;
            $display("FAIL abort_stale_ack: got %b want 000", a_ack);
        end
        tick();
        total++;
        if (a_rden !== 1'b1 || a_vaddr !== 15'h0040 || a_ack !== 3'b000) begin
            bad++;
            $display("FAIL abort_reissue: got rden=%b addr=%h ack=%b want 1/0040/000",
                     a_rden, a_vaddr, a_ack);
        end
        tick();
        tick();
        total++;
        if (a_ack !== 3'b010 || a_rd[1] !== vram_word(15'h0040)) begin
            bad++;
            $display("FAIL abort_new_ack: got ack=%b data=%h want 010/%h", a_ack, a_rd[1],
                     vram_word(15'h0040));
        end
        a_req[1] = 1'b0;
        tick();
        total++;
        if (a_ack !== 3'b000) begin
            bad++;
            $display("FAIL abort_single_ack: got %b want 000", a_ack);
        end
    endtask

    task automatic test_cancel_lat2;
        do_reset();
        b_addr[1] = 16'h0030;
        b_req[1]  = 1'b1;
        tick();
        tick();
        b_req[1] = 1'b0;
        tick();
        b_addr[1] = 16'h0040;
        b_req[1]  = 1'b1;
        tick();
        total++;
        if (b_ack !== 3'b000 || b_rden !== 1'b0) begin
            bad++;
            $display("FAIL cancel_stale: got ack=%b rden=%b want 000/0", b_ack, b_rden);
        end
        tick();
        total++;
        if (b_rden !== 1'b1 || b_vaddr !== 15'h0040) begin
            bad++;
            $display("FAIL cancel_reissue: got rden=%b addr=%h want 1/0040", b_rden, b_vaddr);
        end
        tick();
        tick();
        total++;
        if (b_ack !== 3'b000) begin
            bad++;
            $display("FAIL cancel_early: got %b want 000", b_ack);
        end
        tick();
        total++;
        if (b_ack !== 3'b010 || b_rd[1] !== vram_word(15'h0040)) begin
            bad++;
            $display("FAIL cancel_new_ack: got ack=%b data=%h want 010/%h", b_ack, b_rd[1],
                     vram_word(15'h0040));
        end
        b_req[1] = 1'b0;
        tick();
    endtask

    task automatic test_latency2;
        do_reset();
        b_addr[2] = 16'h1234;
        b_req[2]  = 1'b1;
        tick();
        total++;
        if (b_rden !== 1'b1 || b_vaddr !== 15'h1234) begin
            bad++;
            $display("FAIL lat2_issue: got rden=%b addr=%h want 1/1234", b_rden, b_vaddr);
        end
        tick();
        tick();
        total++;
        if (b_ack !== 3'b000) begin
            bad++;
            $display("FAIL lat2_early: got %b want 000", b_ack);
        end
        tick();
        total++;
        if (b_ack !== 3'b100 || b_rd[2] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL lat2_ack: got ack=%b data=%h want 100/deadbeef", b_ack, b_rd[2]);
        end
        b_req[2] = 1'b0;
        tick();
        total++;
        if (b_ack !== 3'b000) begin
            bad++;
            $display("FAIL lat2_pulse: got %b want 000", b_ack);
        end
    endtask

    task automatic test_no_starvation;
        int waitc [3];
        int maxw;
        int nacks;
        do_reset();
        waitc = '{0, 0, 0};
        maxw  = 0;
        nacks = 0;
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (a_ack[i]) begin
                    nacks++;
                    total++;
                    if (a_req[i] !== 1'b1 || a_rd[i] !== vram_word(a_addr[i][14:0])) begin
                        bad++;
                        $display("FAIL rand_ack port%0d: got req=%b data=%h want 1/%h", i,
                                 a_req[i], a_rd[i], vram_word(a_addr[i][14:0]));
                    end
                    a_req[i] = 1'b0;
                    waitc[i] = 0;
                end else if (a_req[i]) begin
                    waitc[i]++;
                    if (waitc[i] > maxw) maxw = waitc[i];
                end else if ($urandom_range(0, 1) == 1) begin
                    a_addr[i] = 16'($urandom);
                    a_req[i]  = 1'b1;
                end
            end
            tick();
        end
        a_req = 3'b000;
        total++;
        if (maxw > 6) begin
            bad++;
            $display("FAIL rand_starvation: got max wait %0d want <= 6", maxw);
        end
        total++;
        if (nacks < 20) begin
            bad++;
            $display("FAIL rand_throughput: got %0d acks want >= 20", nacks);
        end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        a_addr[0] = 16'h0050;
        b_addr[0] = 16'h0050;
        a_req[0]  = 1'b1;
        b_req[0]  = 1'b1;
        tick();
        tick();
        rst   = 1'b1;
        a_req = 3'b000;
        b_req = 3'b000;
        #1;
        total++;
        if ({a_ack, b_ack, a_rden, b_rden} !== 8'h00 || {a_vaddr, b_vaddr} !== 30'h0) begin
            bad++;
            $display("FAIL midrst_outputs: got ctrl=%b addr=%h/%h want 0/0/0",
                     {a_ack, b_ack, a_rden, b_rden}, a_vaddr, b_vaddr);
        end
        total++;
        if (a_rd[0] !== 32'h0 || b_rd[0] !== 32'h0) begin
            bad++;
            $display("FAIL midrst_rddata: got %h/%h want 0/0", a_rd[0], b_rd[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (a_ack !== 3'b000 || b_ack !== 3'b000) begin
                bad++;
                $display("FAIL midrst_ghost_ack%0d: got %b/%b want 000/000", c, a_ack, b_ack);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            a_addr[i] = 16'h0;
            b_addr[i] = 16'h0;
        end
        test_reset();
        test_single();
        test_bit15();
        test_contention();
        test_abort();
        test_cancel_lat2();
        test_latency2();
        test_no_starvation();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_fetch_responder.md
# vram_fetch_responder

Responder side of the renderer bus-master fetch protocol. It serves three read initiators (layer 0 renderer, layer 1 renderer, sprite renderer) from one shared synchronous 32-bit VRAM read port. Requests are arbitrated round-robin, and up to one read is issued per cycle. Each initiator gets a single-cycle ack, with its 32-bit data valid in the same cycle. The block sits between the renderers and the VRAM read port of the video memory.

## Interface

Parameters:
- RD_LATENCY, 1: VRAM read latency in cycles from `vram_rden` to valid `vram_rddata`. Legal values are 1 and 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- l0_addr / l1_addr / spr_addr  in  16  word address per initiator; bit 15 ignored
- l0_strobe / l1_strobe / spr_strobe  in  1  request; held high with a stable address until ack
- l0_ack / l1_ack / spr_ack  out  1  single-cycle completion pulse, registered
- l0_rddata / l1_rddata / spr_rddata  out  32  read data; valid in the ack cycle
- vram_addr  out  15  VRAM word address, registered
- vram_rden  out  1  VRAM read enable, registered
- vram_rddata  in  32  VRAM data, valid RD_LATENCY cycles after `vram_rden`

## Operation

- Port indices: 0 = l0, 1 = l1, 2 = spr.
- Per-port state:
  - `inflight`: a read is issued and not yet retired.
  - `cancel`: the initiator dropped its strobe while `inflight`.
- Eligibility: a port is eligible when strobe=1 and inflight=0.
- Arbitration:
  - `last_r` (2 bits) holds the last-granted port.
  - The search order starts at (last_r+1) mod 3 and wraps.
  - The first eligible port is granted, and `last_r` updates to it.
  - At most one grant per cycle.
- Issue on grant (registered):
  - vram_rden=1, vram_addr=addr[14:0].
  - Set `inflight` for the granted port.
  - Push {valid, port} into a tag pipeline of depth RD_LATENCY.
  - With no grant: vram_rden=0 and vram_addr holds its value.
- Cancel: any cycle a port has inflight=1 and strobe=0 sets `cancel`.
- Retire, in the cycle the tag emerges (that cycle's `vram_rddata` is valid):
  - If the port's `cancel` is 0 and strobe is still 1, register ack=1 and rddata=vram_rddata for that port on the next edge.
  - Otherwise register no ack and leave rddata unchanged.
  - In either case clear both `inflight` and `cancel` for that port on the same edge.
- Ack and rddata only go to the retiring port. The other ports' ack=0 and their rddata hold their values.
- Ack is never combinationally dependent on strobe in the ack cycle. Initiators mask strobe with ack, so the strobe check happens one cycle earlier, at retire.
- A port re-requesting after a cancel is not eligible until its old read retires, so stale data can never be acked to a new request.

## Timing

- Reset values:
  - Outputs: all acks 0, all rddata 0, vram_rden 0, vram_addr 0.
  - Internal: inflight/cancel 0, tag pipeline invalid, last_r=2, so port 0 wins first.
- Latency for an uncontested request, where strobe is first high at edge E0:
  - vram_rden=1 after E0.
  - Data arrives RD_LATENCY cycles later; this is the retire cycle.
  - Ack is high in the following cycle.
  - Strobe rise to ack = RD_LATENCY+2 cycles (3 for RD_LATENCY=1).
- Throughput: one issue per cycle aggregate. A single port cannot have more than one outstanding read, so a port with back-to-back requests gets at most one ack per RD_LATENCY+2 cycles plus initiator turnaround.
- Contention: three simultaneous requests from reset are issued on consecutive cycles in order 0, 1, 2. Their acks arrive in the same order on consecutive cycles.
- Simultaneous events in one cycle are independent and all take effect:
  - the retire of port A
  - the grant of port B
  - the cancel detection of port C
- Retire and grant of the same port cannot coincide, because inflight=1 blocks the grant.
- Reset mid-operation: all in-flight reads are discarded. VRAM data returning after reset is ignored, because the pipeline is invalid.

## Test plan

- Single request: spr_strobe=1, spr_addr=0x1234, RD_LATENCY=1, VRAM returns 0xDEADBEEF -> vram_addr=0x1234 with vram_rden=1 one cycle later; spr_ack=1 for exactly one cycle, 3 cycles after the strobe rise, with spr_rddata=0xDEADBEEF.
- Bit 15 ignored: l0_addr=0x8010 -> vram_addr=0x0010.
- Contention from reset: all three strobe at once, addresses 0x0001, 0x0002, 0x0003 -> vram_addr sequence 1, 2, 3 on consecutive cycles; acks l0, l1, spr on consecutive cycles with matching data. A second round with l1 and spr only -> grant order follows last_r (l1 then spr, 0 skipped), with no starvation over 100 random cycles.
- Abort: l1 strobe drops one cycle after issue, then re-asserts at 0x0040 in the next cycle -> no l1_ack for the first request; the new read is issued only after the old tag retires; exactly one l1_ack, carrying the 0x0040 data.
- RD_LATENCY=2: repeat the single-request test -> ack exactly 4 cycles after the strobe rise.
- Reset mid-flight: assert rst one cycle after issue -> all outputs at reset values; no ack after rst release even though VRAM returns data.
